decode_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one resource between up to REQ_NUM requesters.
- Outputs a registered binary grant index and its one-hot decoded form, so a single grant bus drives both the index consumers and the per-requester select lines.
- Holds a grant until the owner releases it or a hold-timeout expires.
- Sits between the requester blocks and the shared resource, in the same design tier as the variable-width decoders.

---
 rtl/decode_rr_arbiter_if.sv | 28 ++
 rtl/decode_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_decode_rr_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/decode_rr_arbiter_if.sv
// Request/grant bus between the requester blocks and the round-robin arbiter.
//
// Handshake: a requester holds its REQ_IN bit high for as long as it wants the
// resource (level, no per-cycle handshake). While GRANT_VALID_OUT is high,
// GRANT_IDX_OUT / GRANT_OH_OUT name the owner; the owner ends its tenure with a
// one-cycle DONE_IN strobe or by dropping its REQ_IN bit, and the arbiter
// may also revoke the grant itself, flagged by a one-cycle TIMEOUT_OUT.
interface decode_rr_arbiter_if #(
    parameter int REQ_BITS = 4,
    parameter int REQ_NUM  = 16
);
    logic [REQ_NUM-1:0]  REQ_IN;
    logic                DONE_IN;
    logic                GRANT_VALID_OUT;
    logic [REQ_BITS-1:0] GRANT_IDX_OUT;
    logic [REQ_NUM-1:0]  GRANT_OH_OUT;
    logic                TIMEOUT_OUT;

    modport master (
        output REQ_IN, DONE_IN,
        input  GRANT_VALID_OUT, GRANT_IDX_OUT, GRANT_OH_OUT, TIMEOUT_OUT
    );

    modport slave (
        input  REQ_IN, DONE_IN,
        output GRANT_VALID_OUT, GRANT_IDX_OUT, GRANT_OH_OUT, TIMEOUT_OUT
    );
endinterface

// File: rtl/decode_rr_arbiter.sv
// Round-robin arbiter with registered binary and one-hot grant outputs.
// A grant lasts until the owner strobes DONE_IN, drops its request, or the
// hold counter reaches MAX_HOLD cycles (MAX_HOLD = 0 disables the timeout).
// Each release is followed by one IDLE cycle in which the next owner is picked.
module decode_rr_arbiter #(
    parameter int REQ_BITS  = 4,
    parameter int REQ_NUM   = 16,
    parameter int HOLD_BITS = 8,
    parameter int MAX_HOLD  = 200
) (
    input  logic                CLK,
    input  logic                RST_N,
    decode_rr_arbiter_if.slave  bus,
    output logic                state_dbg
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [REQ_BITS-1:0]  LAST_RST  = REQ_BITS'(REQ_NUM - 1);
    localparam logic [HOLD_BITS-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : HOLD_BITS'(MAX_HOLD - 1);
    localparam logic [REQ_BITS:0]    NUM_W     = (REQ_BITS + 1)'(REQ_NUM);

    state_e               state_q, state_d;
    logic [REQ_BITS-1:0]  last_q, last_d;
    logic [REQ_BITS-1:0]  idx_q, idx_d;
    logic                 valid_q, valid_d;
    logic [REQ_NUM-1:0]   oh_q, oh_d;
    logic                 timeout_q, timeout_d;
    logic [HOLD_BITS-1:0] cnt_q, cnt_d;

    logic                 pick_found;
    logic [REQ_BITS-1:0]  pick_idx;
    logic [REQ_BITS:0]    cand;
    logic                 rel_done, rel_drop, rel_time;

    // Rotating priority search: first requester at or after last+1, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int off = 1; off <= REQ_NUM; off++) begin
            cand = {1'b0, last_q} + (REQ_BITS + 1)'(off);
            if (cand >= NUM_W) begin
                cand = cand - NUM_W;
            end
            if (!pick_found && bus.REQ_IN[cand[REQ_BITS-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[REQ_BITS-1:0];
            end
        end
    end

    // Release causes for the current owner; only the timeout one raises a pulse.
    always_comb begin
        rel_done = bus.DONE_IN;
        rel_drop = !bus.REQ_IN[idx_q];
        rel_time = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
    end

    // Next-state and next-output logic for the IDLE/GRANT controller.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        oh_d      = oh_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d        = GRANT;
                    valid_d        = 1'b1;
                    idx_d          = pick_idx;
                    oh_d           = '0;
                    oh_d[pick_idx] = 1'b1;
                    cnt_d          = '0;
                end
            end
            GRANT: begin
                if (rel_done || rel_drop || rel_time) begin
                    state_d   = IDLE;
                    valid_d   = 1'b0;
                    oh_d      = '0;
                    last_d    = idx_q;
                    timeout_d = rel_time && !rel_done && !rel_drop;
                end else if (cnt_q != '1) begin
                    // Saturate rather than wrap when the timeout is disabled.
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                oh_d    = '0;
            end
        endcase
    end

    // State and output registers; reset drops any grant at once.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            last_q    <= LAST_RST;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            oh_q      <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            oh_q      <= oh_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.GRANT_VALID_OUT = valid_q;
    assign bus.GRANT_IDX_OUT   = idx_q;
    assign bus.GRANT_OH_OUT    = oh_q;
    assign bus.TIMEOUT_OUT     = timeout_q;
    assign state_dbg           = (state_q == GRANT);
endmodule

// File: tb/tb_decode_rr_arbiter.sv
// Bench for decode_rr_arbiter: expected grant indices are queued as stimulus
// is applied and popped by a monitor on every rising grant.
module tb_decode_rr_arbiter;
    localparam int REQ_BITS = 4;
    localparam int REQ_NUM  = 16;

    // ---------------- clock / reset ----------------
    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    logic state_dbg;

    always #5 CLK = ~CLK;

    decode_rr_arbiter_if #(.REQ_BITS(REQ_BITS), .REQ_NUM(REQ_NUM)) bus ();

    decode_rr_arbiter #(
        .REQ_BITS (REQ_BITS),
        .REQ_NUM  (REQ_NUM),
        .HOLD_BITS(8),
        .MAX_HOLD (200)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    // ---------------- scoreboard ----------------
    int                  n_cmp = 0;
    int                  n_bad = 0;
    logic [REQ_BITS-1:0] exp_q[$];
    logic                prev_valid = 1'b0;
    logic [REQ_NUM-1:0]  exp_oh;
    logic [REQ_BITS-1:0] exp_idx;
    int                  hold;
    int                  order [5];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-cycle invariant plus in-order comparison of each new grant.
    always @(negedge CLK) begin
        exp_oh = '0;
        if (bus.GRANT_VALID_OUT) exp_oh[bus.GRANT_IDX_OUT] = 1'b1;
        check("oh_invariant", 32'(bus.GRANT_OH_OUT), 32'(exp_oh));
        check("state_dbg", 32'(state_dbg), 32'(bus.GRANT_VALID_OUT));
        if (bus.GRANT_VALID_OUT && !prev_valid) begin
            check("grant_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_idx = exp_q.pop_front();
                check("grant_idx", 32'(bus.GRANT_IDX_OUT), 32'(exp_idx));
            end
        end
        prev_valid <= bus.GRANT_VALID_OUT;
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge with a grant active: pulse DONE_IN for one edge.
    task automatic release_done();
        bus.DONE_IN = 1'b1;
        @(posedge CLK);
        #1;
        bus.DONE_IN = 1'b0;
        @(negedge CLK);
        check("idle_gap_valid", 32'(bus.GRANT_VALID_OUT), 32'd0);
        check("idle_gap_timeout", 32'(bus.TIMEOUT_OUT), 32'd0);
    endtask

    task automatic await_grant(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (bus.GRANT_VALID_OUT) break;
        end
        check("grant_in_budget", 32'(bus.GRANT_VALID_OUT), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.REQ_IN  = '0;
        bus.DONE_IN = 1'b0;
        order       = '{5, 10, 15, 0, 5};

        repeat (3) @(negedge CLK);
        check("rst_valid", 32'(bus.GRANT_VALID_OUT), 32'd0);
        check("rst_idx", 32'(bus.GRANT_IDX_OUT), 32'd0);
        check("rst_oh", 32'(bus.GRANT_OH_OUT), 32'd0);
        check("rst_timeout", 32'(bus.TIMEOUT_OUT), 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        check("idle_no_req", 32'(bus.GRANT_VALID_OUT), 32'd0);

        // Single requester 0: one-cycle latency, DONE release, re-grant.
        bus.REQ_IN = 16'h0001;
        exp_q.push_back(4'd0);
        @(negedge CLK);
        check("t1_latency", 32'(bus.GRANT_VALID_OUT), 32'd1);
        check("t1_oh", 32'(bus.GRANT_OH_OUT), 32'h0001);
        exp_q.push_back(4'd0);
        release_done();
        await_grant(1);

        // Rotation over 0, 5, 10, 15 with one idle cycle between grants.
        bus.REQ_IN = 16'h8421;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(REQ_BITS'(order[k]));
            release_done();
            await_grant(1);
        end

        // Owner 5 withdraws; requester 2 then holds until the timeout.
        bus.REQ_IN = 16'h0004;
        exp_q.push_back(4'd2);
        @(negedge CLK);
        check("drop_release", 32'(bus.GRANT_VALID_OUT), 32'd0);
        await_grant(1);
        hold = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (!bus.GRANT_VALID_OUT) break;
            hold++;
        end
        check("hold_len", 32'(hold), 32'd200);
        check("timeout_pulse", 32'(bus.TIMEOUT_OUT), 32'd1);
        exp_q.push_back(4'd2);
        @(negedge CLK);
        check("timeout_one_cycle", 32'(bus.TIMEOUT_OUT), 32'd0);
        check("regrant_after_timeout", 32'(bus.GRANT_VALID_OUT), 32'd1);

        // DONE_IN coinciding with the last hold cycle: normal release.
        repeat (199) @(negedge CLK);
        check("hold_199_valid", 32'(bus.GRANT_VALID_OUT), 32'd1);
        exp_q.push_back(4'd2);
        release_done();
        await_grant(1);

        // Withdraw-driven releases: 2 -> 3, then 3 drops with 9 waiting.
        bus.REQ_IN = 16'h0208;
        exp_q.push_back(4'd3);
        @(negedge CLK);
        check("drop2_release", 32'(bus.GRANT_VALID_OUT), 32'd0);
        await_grant(1);
        bus.REQ_IN = 16'h0200;
        exp_q.push_back(4'd9);
        @(negedge CLK);
        check("drop3_release", 32'(bus.GRANT_VALID_OUT), 32'd0);
        await_grant(1);
        check("idx_9", 32'(bus.GRANT_IDX_OUT), 32'd9);

        // Asynchronous reset mid-grant.
        @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        check("async_valid", 32'(bus.GRANT_VALID_OUT), 32'd0);
        check("async_idx", 32'(bus.GRANT_IDX_OUT), 32'd0);
        check("async_oh", 32'(bus.GRANT_OH_OUT), 32'd0);
        check("async_timeout", 32'(bus.TIMEOUT_OUT), 32'd0);
        bus.REQ_IN = 16'hFFFF;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        exp_q.push_back(4'd0);
        await_grant(1);
        exp_q.push_back(4'd1);
        release_done();
        await_grant(1);

        @(negedge CLK);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
